mem_dados_resp: RTL and testbench

- Data-memory responder: the memory-side end of the pipeline's load/store port.
- Accepts one request at a time from the MEM stage through a valid/ready handshake.
- Models a configurable number of wait states, performs the word read or write, and returns a one-cycle response pulse with read data or an error flag.
- Replaces the fixed-latency memory block so the pipeline's stall logic can be exercised.

---
 rtl/mem_dados_pkg.sv | 28 ++
 rtl/mem_dados_resp_if.sv | 37 +++
 rtl/mem_dados_ram.sv | 45 ++++
 rtl/mem_dados_resp.sv | 149 ++++++++++++++
 tb/tb_mem_dados_resp.sv | 326 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_dados_pkg.sv
// Shared types and constants for the data-memory responder and the pipeline's control decode.
package mem_dados_pkg;

    localparam int         WORD_W      = 32;
    localparam logic [7:0] ERR_CNT_MAX = 8'd255;

    localparam logic [5:0] OPC_LW = 6'b100011;
    localparam logic [5:0] OPC_SW = 6'b101011;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_WAIT = WAIT;
    localparam logic [1:0] ST_RESP = RESP;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        if (v == ERR_CNT_MAX) begin
            sat_inc8 = v;
        end else begin
            sat_inc8 = v + 8'd1;
        end
    endfunction

endpackage

// File: rtl/mem_dados_resp_if.sv
// Load/store bus between the MEM stage (master) and the data-memory responder (slave).
// md_in_be exists only when MEM_DADOS_BYTE_EN is defined.
interface mem_dados_resp_if
    import mem_dados_pkg::*;
#(
    parameter int ADDR_W = 10
);
    logic              md_in_req_valid;
    logic              md_out_req_ready;
    logic              md_in_we;
    logic [ADDR_W-1:0] md_in_addr;
    logic [WORD_W-1:0] md_in_wdata;
`ifdef MEM_DADOS_BYTE_EN
    logic [3:0]        md_in_be;
`endif
    logic              md_out_rsp_valid;
    logic [WORD_W-1:0] md_out_rdata;
    logic              md_out_err;
    logic [7:0]        md_out_err_cnt;

    modport slave (
`ifdef MEM_DADOS_BYTE_EN
        input  md_in_be,
`endif
        input  md_in_req_valid, md_in_we, md_in_addr, md_in_wdata,
        output md_out_req_ready, md_out_rsp_valid, md_out_rdata, md_out_err, md_out_err_cnt
    );

    modport master (
`ifdef MEM_DADOS_BYTE_EN
        output md_in_be,
`endif
        output md_in_req_valid, md_in_we, md_in_addr, md_in_wdata,
        input  md_out_req_ready, md_out_rsp_valid, md_out_rdata, md_out_err, md_out_err_cnt
    );

endinterface

// File: rtl/mem_dados_ram.sv
// Single-port synchronous word RAM with byte write mask; the read register doubles as the
// responder's rdata output, so it holds between reads and can be cleared for errored accesses.
module mem_dados_ram
    import mem_dados_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int AW    = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              we,
    input  logic              clr,
    input  logic [AW-1:0]     addr,
    input  logic [WORD_W-1:0] wdata,
    input  logic [3:0]        be,
    output logic [WORD_W-1:0] q
);
    logic [WORD_W-1:0] mem_r [DEPTH];

    // Byte-masked write port; contents survive reset, but no write lands on a reset edge.
    always_ff @(posedge clk) begin
        if (!rst && en && we) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) begin
                    mem_r[addr][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    // Read register: loaded by reads, zeroed by reset or an errored access, held otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= {WORD_W{1'b0}};
        end else if (clr) begin
            q <= {WORD_W{1'b0}};
        end else if (en && !we) begin
            q <= mem_r[addr];
        end else begin
            q <= q;
        end
    end

endmodule

// File: rtl/mem_dados_resp.sv
// Data-memory responder: one request at a time, WAIT_STATES wait cycles, one-cycle response pulse.
// Define MEM_DADOS_BYTE_EN to enable byte-masked stores through md_in_be.
module mem_dados_resp
    import mem_dados_pkg::*;
#(
    parameter int DEPTH       = 1024,
    parameter int WAIT_STATES = 2,
    parameter int ADDR_W      = 10
) (
    input logic             md_in_clk,
    input logic             md_in_rst,
    mem_dados_resp_if.slave md_bus
);
    localparam int RAM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [1:0]        state_r;
    logic [1:0]        state_nx_s;
    logic [3:0]        cnt_r;
    logic [3:0]        cnt_nx_s;
    logic              we_r;
    logic [ADDR_W-1:0] addr_r;
    logic [WORD_W-1:0] wdata_r;
    logic [3:0]        be_r;
    logic              ready_r;
    logic              rsp_valid_r;
    logic              err_r;
    logic [7:0]        err_cnt_r;

    logic              accept_s;
    logic              acc_go_s;
    logic              acc_we_s;
    logic [ADDR_W-1:0] acc_addr_s;
    logic [WORD_W-1:0] acc_wdata_s;
    logic [3:0]        acc_be_s;
    logic [3:0]        req_be_s;
    logic              in_range_s;
    logic              ram_en_s;
    logic              ram_clr_s;
    logic [WORD_W-1:0] ram_q_s;

`ifdef MEM_DADOS_BYTE_EN
    assign req_be_s = md_bus.md_in_be;
`else
    assign req_be_s = 4'hF;
`endif

    // Next state, wait count and access selection; with zero wait states the access uses the live request.
    always_comb begin
        state_nx_s  = state_r;
        cnt_nx_s    = cnt_r;
        accept_s    = 1'b0;
        acc_go_s    = 1'b0;
        acc_we_s    = we_r;
        acc_addr_s  = addr_r;
        acc_wdata_s = wdata_r;
        acc_be_s    = be_r;
        case (state_r)
            ST_IDLE: begin
                if (md_bus.md_in_req_valid) begin
                    accept_s = 1'b1;
                    if (WAIT_STATES == 0) begin
                        acc_go_s    = 1'b1;
                        acc_we_s    = md_bus.md_in_we;
                        acc_addr_s  = md_bus.md_in_addr;
                        acc_wdata_s = md_bus.md_in_wdata;
                        acc_be_s    = req_be_s;
                        state_nx_s  = ST_RESP;
                    end else begin
                        cnt_nx_s   = 4'(WAIT_STATES - 1);
                        state_nx_s = ST_WAIT;
                    end
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_r == 4'd0) begin
                    acc_go_s   = 1'b1;
                    state_nx_s = ST_RESP;
                end else begin
                    cnt_nx_s = cnt_r - 4'd1;
                end
            end
            ST_RESP: begin
                state_nx_s = ST_IDLE;
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    assign in_range_s = (32'(acc_addr_s) < 32'(DEPTH));
    assign ram_en_s   = acc_go_s & in_range_s;
    assign ram_clr_s  = acc_go_s & ~in_range_s;

    // Control, handshake and error-count registers; reset drops any request in flight.
    always_ff @(posedge md_in_clk) begin
        if (md_in_rst) begin
            state_r     <= ST_IDLE;
            cnt_r       <= 4'd0;
            ready_r     <= 1'b1;
            rsp_valid_r <= 1'b0;
            err_r       <= 1'b0;
            err_cnt_r   <= 8'd0;
            we_r        <= 1'b0;
            addr_r      <= {ADDR_W{1'b0}};
            wdata_r     <= {WORD_W{1'b0}};
            be_r        <= 4'h0;
        end else begin
            state_r     <= state_nx_s;
            cnt_r       <= cnt_nx_s;
            ready_r     <= (state_nx_s == ST_IDLE);
            rsp_valid_r <= acc_go_s;
            err_r       <= ram_clr_s;
            if (ram_clr_s) begin
                err_cnt_r <= sat_inc8(err_cnt_r);
            end
            if (accept_s) begin
                we_r    <= md_bus.md_in_we;
                addr_r  <= md_bus.md_in_addr;
                wdata_r <= md_bus.md_in_wdata;
                be_r    <= req_be_s;
            end
        end
    end

    mem_dados_ram #(
        .DEPTH(DEPTH),
        .AW   (RAM_AW)
    ) u_ram (
        .clk  (md_in_clk),
        .rst  (md_in_rst),
        .en   (ram_en_s),
        .we   (acc_we_s),
        .clr  (ram_clr_s),
        .addr (acc_addr_s[RAM_AW-1:0]),
        .wdata(acc_wdata_s),
        .be   (acc_be_s),
        .q    (ram_q_s)
    );

    assign md_bus.md_out_req_ready = ready_r;
    assign md_bus.md_out_rsp_valid = rsp_valid_r;
    assign md_bus.md_out_rdata     = ram_q_s;
    assign md_bus.md_out_err       = err_r;
    assign md_bus.md_out_err_cnt   = err_cnt_r;

endmodule

// File: tb/tb_mem_dados_resp.sv
// Bench for mem_dados_resp: instance A (DEPTH=1024, WAIT_STATES=2), instance B (DEPTH=512, WAIT_STATES=0).
// Table vectors, hand-written handshake/reset sequences and random traffic against a memory model.
module tb_mem_dados_resp;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    localparam bit BE_ON =
`ifdef MEM_DADOS_BYTE_EN
        1'b1;
`else
        1'b0;
`endif

    mem_dados_resp_if #(.ADDR_W(10)) bus_a ();
    mem_dados_resp_if #(.ADDR_W(10)) bus_b ();

    mem_dados_resp #(.DEPTH(1024), .WAIT_STATES(2), .ADDR_W(10)) u_a (
        .md_in_clk(clk), .md_in_rst(rst), .md_bus(bus_a));
    mem_dados_resp #(.DEPTH(512), .WAIT_STATES(0), .ADDR_W(10)) u_b (
        .md_in_clk(clk), .md_in_rst(rst), .md_bus(bus_b));

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference model: word array per instance, last returned data, total errored accesses.
    logic [31:0] m_mem   [2][1024];
    bit          m_known [2][1024];
    logic [31:0] m_rdata [2];
    int          m_errs  [2];

    typedef struct {
        int          sel;
        logic        we;
        logic [9:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        logic [7:0]  exp_cnt;
    } vec_t;

    vec_t tbl [13];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic int ws_of(input int sel);
        return (sel == 0) ? 2 : 0;
    endfunction
    function automatic int depth_of(input int sel);
        return (sel == 0) ? 1024 : 512;
    endfunction
    function automatic logic rdy(input int sel);
        return (sel == 0) ? bus_a.md_out_req_ready : bus_b.md_out_req_ready;
    endfunction
    function automatic logic rsp(input int sel);
        return (sel == 0) ? bus_a.md_out_rsp_valid : bus_b.md_out_rsp_valid;
    endfunction
    function automatic logic [31:0] rdat(input int sel);
        return (sel == 0) ? bus_a.md_out_rdata : bus_b.md_out_rdata;
    endfunction
    function automatic logic errf(input int sel);
        return (sel == 0) ? bus_a.md_out_err : bus_b.md_out_err;
    endfunction
    function automatic logic [7:0] ecnt(input int sel);
        return (sel == 0) ? bus_a.md_out_err_cnt : bus_b.md_out_err_cnt;
    endfunction

    task automatic drive(input int sel, input logic v, input logic we, input logic [9:0] addr,
                         input logic [31:0] wdata, input logic [3:0] be);
        if (sel == 0) begin
            bus_a.md_in_req_valid = v;
            bus_a.md_in_we        = we;
            bus_a.md_in_addr      = addr;
            bus_a.md_in_wdata     = wdata;
`ifdef MEM_DADOS_BYTE_EN
            bus_a.md_in_be        = be;
`endif
        end else begin
            bus_b.md_in_req_valid = v;
            bus_b.md_in_we        = we;
            bus_b.md_in_addr      = addr;
            bus_b.md_in_wdata     = wdata;
`ifdef MEM_DADOS_BYTE_EN
            bus_b.md_in_be        = be;
`endif
        end
    endtask

    task automatic model_reset();
        for (int s = 0; s < 2; s++) begin
            m_rdata[s] = 32'h0;
            m_errs[s]  = 0;
        end
    endtask

    task automatic model_access(input int sel, input logic we, input logic [9:0] addr,
                                input logic [31:0] wdata, input logic [3:0] be,
                                output logic [31:0] er, output logic ee, output logic [7:0] ec,
                                output logic kn);
        logic [3:0] bm;
        bm = BE_ON ? be : 4'hF;
        kn = 1'b1;
        if (int'(addr) >= depth_of(sel)) begin
            ee = 1'b1;
            m_rdata[sel] = 32'h0;
            m_errs[sel]++;
        end else begin
            ee = 1'b0;
            if (we) begin
                for (int b = 0; b < 4; b++) begin
                    if (bm[b]) m_mem[sel][addr][8*b +: 8] = wdata[8*b +: 8];
                end
                if (bm == 4'hF) m_known[sel][addr] = 1'b1;
            end else begin
                kn = m_known[sel][addr];
                m_rdata[sel] = m_mem[sel][addr];
            end
        end
        er = m_rdata[sel];
        ec = (m_errs[sel] > 255) ? 8'd255 : 8'(m_errs[sel]);
    endtask

    // One request on instance sel; returns the response and its latency in edges after acceptance.
    task automatic txn(input int sel, input logic we, input logic [9:0] addr, input logic [31:0] wdata,
                       input logic [3:0] be, output logic [31:0] r, output logic e,
                       output logic [7:0] c, output int lat);
        int   guard;
        logic low_ok;
        guard = 0;
        r = 32'hx; e = 1'bx; c = 8'hx; lat = -1; low_ok = 1'b1;
        while (rdy(sel) !== 1'b1 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        chk("ready_wait", 32'(guard < 20), 32'd1);
        drive(sel, 1'b1, we, addr, wdata, be);
        @(posedge clk);
        @(negedge clk);
        drive(sel, 1'b0, 1'b0, 10'd0, 32'd0, 4'hF);
        for (int k = 0; k < 20; k++) begin
            if (k > 0) @(negedge clk);
            if (rdy(sel) !== 1'b0) low_ok = 1'b0;
            if (rsp(sel) === 1'b1) begin
                lat = k;
                r = rdat(sel);
                e = errf(sel);
                c = ecnt(sel);
                break;
            end
        end
        chk("rsp_timeout", 32'(lat >= 0), 32'd1);
        chk("ready_low", 32'(low_ok), 32'd1);
        @(negedge clk);
        chk("rsp_single", 32'(rsp(sel)), 32'd0);
        chk("ready_back", 32'(rdy(sel)), 32'd1);
        chk("rdata_hold", rdat(sel), r);
    endtask

    task automatic run(input int sel, input logic we, input logic [9:0] addr, input logic [31:0] wdata,
                       input logic [3:0] be, input string nm, output logic [31:0] r);
        logic [31:0] er;
        logic        ee, kn, e;
        logic [7:0]  ec, c;
        int          lat;
        model_access(sel, we, addr, wdata, be, er, ee, ec, kn);
        txn(sel, we, addr, wdata, be, r, e, c, lat);
        chk({nm, "_model_init"}, 32'(kn), 32'd1);
        chk({nm, "_rdata"}, r, er);
        chk({nm, "_err"}, 32'(e), 32'(ee));
        chk({nm, "_errcnt"}, 32'(c), 32'(ec));
        chk({nm, "_latency"}, 32'(lat), 32'(ws_of(sel)));
    endtask

    task automatic check_reset_vals(input string nm);
        for (int s = 0; s < 2; s++) begin
            chk({nm, "_ready"},   32'(rdy(s)),  32'd1);
            chk({nm, "_rsp"},     32'(rsp(s)),  32'd0);
            chk({nm, "_rdata"},   rdat(s),      32'd0);
            chk({nm, "_err"},     32'(errf(s)), 32'd0);
            chk({nm, "_err_cnt"}, 32'(ecnt(s)), 32'd0);
        end
    endtask

    initial begin
        logic [31:0] r, er;
        logic        e, ee, kn;
        logic [7:0]  c, ec;
        int          lat;
        logic [7:0]  mask, rmask;
        logic [31:0] rd [8];
        logic        seen;

        tbl[0]  = '{0, 1'b1, 10'd5,    32'hDEADBEEF, 32'h00000000, 1'b0, 8'd0};
        tbl[1]  = '{0, 1'b0, 10'd5,    32'h00000000, 32'hDEADBEEF, 1'b0, 8'd0};
        tbl[2]  = '{0, 1'b1, 10'd1023, 32'hCAFEF00D, 32'hDEADBEEF, 1'b0, 8'd0};
        tbl[3]  = '{0, 1'b0, 10'd1023, 32'h00000000, 32'hCAFEF00D, 1'b0, 8'd0};
        tbl[4]  = '{0, 1'b0, 10'd5,    32'h00000000, 32'hDEADBEEF, 1'b0, 8'd0};
        tbl[5]  = '{1, 1'b1, 10'd511,  32'h0BADF00D, 32'h00000000, 1'b0, 8'd0};
        tbl[6]  = '{1, 1'b0, 10'd511,  32'h00000000, 32'h0BADF00D, 1'b0, 8'd0};
        tbl[7]  = '{1, 1'b1, 10'd188,  32'h55AA55AA, 32'h0BADF00D, 1'b0, 8'd0};
        tbl[8]  = '{1, 1'b0, 10'd600,  32'h00000000, 32'h00000000, 1'b1, 8'd1};
        tbl[9]  = '{1, 1'b1, 10'd700,  32'hFFFFFFFF, 32'h00000000, 1'b1, 8'd2};
        tbl[10] = '{1, 1'b0, 10'd188,  32'h00000000, 32'h55AA55AA, 1'b0, 8'd2};
        tbl[11] = '{1, 1'b0, 10'd511,  32'h00000000, 32'h0BADF00D, 1'b0, 8'd2};
        tbl[12] = '{1, 1'b0, 10'd512,  32'h00000000, 32'h00000000, 1'b1, 8'd3};

        drive(0, 1'b0, 1'b0, 10'd0, 32'd0, 4'hF);
        drive(1, 1'b0, 1'b0, 10'd0, 32'd0, 4'hF);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_reset_vals("reset");
        model_reset();

        for (int i = 0; i < 13; i++) begin
            model_access(tbl[i].sel, tbl[i].we, tbl[i].addr, tbl[i].wdata, 4'hF, er, ee, ec, kn);
            txn(tbl[i].sel, tbl[i].we, tbl[i].addr, tbl[i].wdata, 4'hF, r, e, c, lat);
            chk($sformatf("vec%0d_rdata", i), r, tbl[i].exp_rdata);
            chk($sformatf("vec%0d_err", i), 32'(e), 32'(tbl[i].exp_err));
            chk($sformatf("vec%0d_errcnt", i), 32'(c), 32'(tbl[i].exp_cnt));
            chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(ws_of(tbl[i].sel)));
        end

        // req_valid held through WAIT/RESP with a changing address: only ready-qualified edges accept.
        run(0, 1'b1, 10'd20, 32'hA1A1A1A1, 4'hF, "hold_init", r);
        run(0, 1'b1, 10'd21, 32'hA2A2A2A2, 4'hF, "hold_init", r);
        run(0, 1'b1, 10'd22, 32'hEEEEEEEE, 4'hF, "hold_init", r);
        drive(0, 1'b1, 1'b0, 10'd20, 32'd0, 4'hF);
        mask = 8'h0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            mask[k] = rsp(0);
            rd[k]   = rdat(0);
            drive(0, 1'b1, 1'b0, rdy(0) ? 10'd21 : 10'd22, 32'd0, 4'hF);
        end
        drive(0, 1'b0, 1'b0, 10'd0, 32'd0, 4'hF);
        chk("hold_rsp_pattern", 32'(mask), 32'h44);
        chk("hold_first_data", rd[2], 32'hA1A1A1A1);
        chk("hold_second_data", rd[6], 32'hA2A2A2A2);
        m_rdata[0] = m_mem[0][21];

        // Zero wait states: a held request is accepted every second cycle.
        drive(1, 1'b1, 1'b0, 10'd511, 32'd0, 4'hF);
        mask = 8'h0;
        rmask = 8'h0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            mask[k]  = rsp(1);
            rmask[k] = rdy(1);
            rd[k]    = rdat(1);
        end
        drive(1, 1'b0, 1'b0, 10'd0, 32'd0, 4'hF);
        chk("b2b_rsp_pattern", 32'(mask), 32'h55);
        chk("b2b_ready_pattern", 32'(rmask), 32'hAA);
        chk("b2b_data", rd[6], 32'h0BADF00D);
        m_rdata[1] = m_mem[1][511];

        // Reset while a store sits in WAIT: no response and the store is dropped.
        run(0, 1'b1, 10'd7, 32'h0F0F0F0F, 4'hF, "rw_prior", r);
        drive(0, 1'b1, 1'b1, 10'd7, 32'h12345678, 4'hF);
        @(posedge clk);
        @(negedge clk);
        drive(0, 1'b0, 1'b0, 10'd0, 32'd0, 4'hF);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_reset_vals("rw_reset");
        model_reset();
        seen = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (rsp(0) !== 1'b0) seen = 1'b1;
        end
        chk("rw_no_response", 32'(seen), 32'd0);
        run(0, 1'b0, 10'd7, 32'd0, 4'hF, "rw_load", r);
        chk("rw_prior_kept", r, 32'h0F0F0F0F);

`ifdef MEM_DADOS_BYTE_EN
        run(0, 1'b1, 10'd30, 32'hAABBCCDD, 4'hF, "be_full", r);
        run(0, 1'b1, 10'd30, 32'h11223344, 4'b0101, "be_part", r);
        run(0, 1'b0, 10'd30, 32'd0, 4'h0, "be_load1", r);
        chk("be_merge", r, 32'hAA22CC44);
        run(0, 1'b1, 10'd30, 32'h99999999, 4'h0, "be_zero", r);
        run(0, 1'b0, 10'd30, 32'd0, 4'hF, "be_load2", r);
        chk("be_zero_kept", r, 32'hAA22CC44);
`endif

        for (int s = 0; s < 2; s++) begin
            for (int a = 0; a < 16; a++) begin
                run(s, 1'b1, 10'(a), $urandom, 4'hF, "rnd_init", r);
            end
        end
        for (int i = 0; i < 80; i++) begin
            int          s;
            logic        we;
            logic [9:0]  ad;
            s  = int'($urandom_range(0, 1));
            we = 1'($urandom_range(0, 1));
            if (s == 1 && $urandom_range(0, 3) == 0) ad = 10'($urandom_range(512, 1023));
            else ad = 10'($urandom_range(0, 15));
            run(s, we, ad, $urandom, 4'($urandom_range(0, 15)), "rnd", r);
        end

        for (int i = 0; i < 300; i++) begin
            run(1, 1'b0, 10'(600 + (i % 400)), 32'd0, 4'hF, "sat", r);
        end
        chk("sat_err_cnt", 32'(ecnt(1)), 32'd255);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
